// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit selected by one radix-4 recoding step
    typedef logic [2:0] digit_t;

    localparam digit_t ZERO     = 3'd0;
    localparam digit_t PLUS_A   = 3'd1;
    localparam digit_t PLUS_2A  = 3'd2;
    localparam digit_t MINUS_A  = 3'd3;
    localparam digit_t MINUS_2A = 3'd4;

    // Number of radix-4 steps needed for WIDTH-bit operands extended by two bits
    function automatic int booth_n_iter(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth digit encoder: maps a multiplier triplet to a signed addend
// in {0, +A, +2A, -A, -2A} taken from the extended multiplicand.
module booth_r4_encoder
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]              triplet,
    input  logic signed [WIDTH+1:0] a_ext,
    output logic signed [WIDTH+2:0] addend
);

    digit_t                  sel;
    logic signed [WIDTH+2:0] a_w;

    // Recode the triplet {b[i+1], b[i], b[i-1]} into a digit
    always_comb begin
        sel = ZERO;
        case (triplet)
            3'b001, 3'b010: sel = PLUS_A;
            3'b011:         sel = PLUS_2A;
            3'b100:         sel = MINUS_2A;
            3'b101, 3'b110: sel = MINUS_A;
            default:        sel = ZERO;
        endcase
    end

    // Form the addend one bit wider than the multiplicand so 2A never overflows
    always_comb begin
        a_w    = {a_ext[WIDTH+1], a_ext};
        addend = '0;
        case (sel)
            PLUS_A:   addend = a_w;
            PLUS_2A:  addend = a_w <<< 1;
            MINUS_A:  addend = -a_w;
            MINUS_2A: addend = -(a_w <<< 1);
            default:  addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_multiplier_r4.sv
// Radix-4 Booth sequential multiplier with start/busy/done handshake.
// Retires two multiplier bits per cycle; signed or unsigned per operation.
// Optional macro BOOTH_EARLY_TERM_EN: leave RUN as soon as every remaining
// digit is zero and apply the outstanding shift in one cycle.
module booth_multiplier_r4
    import booth_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int N_ITER = booth_n_iter(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    // Extended operand width, accumulator width, product register width
    localparam int EW = WIDTH + 2;
    localparam int AW = WIDTH + 4;
    localparam int PW = AW + EW + 1;
    localparam int CW = $clog2(N_ITER + 1);

    state_t               state, state_nxt;
    logic signed [EW-1:0] a_ext_q;
    // Layout: {accumulator[AW], multiplier[EW], pending lsb}
    logic [PW-1:0]        prod_q;
    logic [CW-1:0]        count_q;
    logic [2*WIDTH-1:0]   result_q;

    logic signed [WIDTH+2:0] addend;
    logic signed [AW-1:0]    addend_x;
    logic signed [AW-1:0]    acc_sum;
    logic signed [PW-1:0]    p_cat;
    logic signed [PW-1:0]    p_step;
    logic signed [PW-1:0]    p_final;
    logic                    last_step;
    logic                    finish;
    logic [EW-1:0]           a_load;
    logic [EW-1:0]           b_load;
    logic                    unused_bits;

    booth_r4_encoder #(
        .WIDTH (WIDTH)
    ) u_enc (
        .triplet (prod_q[2:0]),
        .a_ext   (a_ext_q),
        .addend  (addend)
    );

    // Operand extension: sign- or zero-extend by two bits
    always_comb begin
        a_load = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
        b_load = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    end

    // One radix-4 step: add digit to the accumulator, then shift right by 2
    always_comb begin
        addend_x  = {addend[WIDTH+2], addend};
        acc_sum   = $signed(prod_q[PW-1:EW+1]) + addend_x;
        p_cat     = {acc_sum, prod_q[EW:0]};
        p_step    = p_cat >>> 2;
        last_step = (count_q == CW'(N_ITER - 1));
    end

`ifdef BOOTH_EARLY_TERM_EN
    logic [CW-1:0] rem;
    logic [CW:0]   shamt;
    logic [PW-1:0] mask;
    logic [PW-1:0] tail;

    // Exit once the unconsumed multiplier bits and pending lsb are uniform
    always_comb begin
        rem     = CW'(N_ITER - 1) - count_q;
        shamt   = {rem, 1'b0};
        mask    = (PW'(2) << shamt) - PW'(1);
        tail    = p_step & mask;
        finish  = last_step || (tail == '0) || (tail == mask);
        p_final = p_step >>> shamt;
    end
`else
    // Fixed latency: finish after the last step, no residual shift
    always_comb begin
        finish  = last_step;
        p_final = p_step;
    end
`endif

    assign unused_bits = ^{p_final[PW-1:2*WIDTH+1], p_final[0]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (finish) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, product iteration and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            a_ext_q  <= '0;
            prod_q   <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_ext_q <= a_load;
                        prod_q  <= {{AW{1'b0}}, b_load, 1'b0};
                        count_q <= '0;
                    end
                end
                RUN: begin
                    prod_q  <= p_step;
                    count_q <= count_q + 1'b1;
                    if (finish) result_q <= p_final[2*WIDTH:1];
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;

endmodule

// File: doc/booth_multiplier_r4.md
Name: booth_multiplier_r4

Overview:
Parametrised radix-4 Booth sequential multiplier. It is the next generation of the team's 32-bit radix-2 booth_multiplier.
- Width is a parameter.
- Signed or unsigned mode is selected per operation.
- An explicit start/busy/done handshake replaces fixed-time sampling.
- It retires two multiplier bits per cycle.
- It sits in the datapath multiplier library and is used by the ALU wrapper and the multiplier comparison benches.

Parameters:
- WIDTH, 32, operand width; must be even and ≥4.
- N_ITER, WIDTH/2+1, radix-4 steps per operation. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- en  in  1  global clock enable; when 0, all registers hold.
- start  in  1  request; sampled only in IDLE with en=1.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; latched with start.
- a  in  WIDTH  multiplicand; latched with start.
- b  in  WIDTH  multiplier; latched with start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result is valid from that cycle onward.
- result  out  2*WIDTH  product; held until the next accepted start.

Behaviour:
- Reset values: busy=0, done=0, result=0; state=IDLE; internal registers=0. Reset overrides en and start.
- Operand extension: a and b are extended to WIDTH+2 bits. Sign-extend when is_signed=1, zero-extend when 0. This gives an exact unsigned product with the same datapath.
- Radix-4 step: examine triplet {b[i+1], b[i], b[i-1]}, with an implicit 0 below the LSB. Add the selected digit in {0, ±A, ±2A} to the upper partial product, then arithmetic-shift the product register right by 2.
- FSM: IDLE → RUN → DONE → IDLE.
  - IDLE: on start=1 with en=1, latch a, b and is_signed; clear the product; count=0; go to RUN. result is unchanged.
  - RUN: with en=1, perform one step and increment count. After step N_ITER, go to DONE and register result = low 2*WIDTH bits of the product.
  - DONE: done=1 for exactly one en-cycle, then go to IDLE.
- Latency: start sampled at cycle 0 → done high at cycle N_ITER+1. For WIDTH=32 this is cycle 18, assuming en is held high.
- en=0: freezes state, count, product and done. A done pulse stretches across en-low cycles.
- start while busy: ignored, with no effect on operands or result.
- Reset mid-operation: returns to IDLE next edge; result=0; no done pulse.
- Overflow cannot occur: the full 2*WIDTH product is always exact.
  - Example: -2^(W-1) × -2^(W-1) = 2^(2W-2).

Optional Feature:
- Macro BOOTH_EARLY_TERM_EN.
- Defined:
  - RUN exits as soon as all remaining unconsumed multiplier bits plus the pending LSB are identical (all 0 or all 1), so every remaining digit is 0.
  - The outstanding 2×(remaining steps) arithmetic shift is applied in one cycle on the DONE transition.
  - A minimum of 1 step is always taken.
  - result is bit-identical to the fixed-latency result; only latency shrinks.
- Undefined: fixed latency of N_ITER+1 cycles for every operand, and no shift-remaining logic is synthesised.

Decomposition:
- Package booth_pkg:
  - state enum (IDLE, RUN, DONE);
  - digit-select encoding constants (ZERO, PLUS_A, PLUS_2A, MINUS_A, MINUS_2A);
  - a function returning N_ITER for a given WIDTH.
- Sub-module booth_r4_encoder: combinational. Maps a 3-bit triplet plus the extended multiplicand to a signed (WIDTH+3)-bit addend. Instantiated once.

Test Plan:
All cases use WIDTH=32, en=1 and macro undefined unless stated.
1. Signed: a=553524, b=840 → result=464960160. done at cycle 18. busy high for cycles 1–18.
2. Signed mixed and extreme:
   - a=-259, b=553524 → -143362716.
   - a=32'h80000000, b=32'h80000000 → 64'h4000_0000_0000_0000.
3. Mode: a=32'hFFFFFFFF, b=2.
   - is_signed=0 → 64'h0000_0001_FFFF_FFFE.
   - is_signed=1 → 64'hFFFF_FFFF_FFFF_FFFE.
4. Handshake:
   - A second start at cycle 5 with a=7, b=7 is ignored; first result is unchanged.
   - Toggling en low for 3 cycles mid-run gives done at cycle 21 with the correct product.
5. Reset: assert reset at cycle 9 of a run → next edge busy=0, result=0, no done pulse. A fresh start then completes normally.
6. BOOTH_EARLY_TERM_EN defined:
   - a=-1199060305, b=1, signed → -1199060305 with done at cycle 2.
   - a=0, b=1348760118 → 0 with latency ≤18.
   - Random signed/unsigned pairs match the undefined build bit-for-bit.
